mmu_translate: RTL and testbench
================================

# mmu_translate

Address-translation sequencer between the pipeline's fetch/memory request ports and the 8-entry TLB lookup array. It accepts one virtual-address request at a time and classifies the segment (kuseg/kseg0/kseg1/kseg2-3). Mapped addresses are driven into the TLB and its combinational result is sampled. The block then returns a physical address or a TLB exception (Refill/Invalid/Modified) on a valid/ready response channel.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort any in-flight request; return to IDLE
- curr_asid  in  8  current EntryHi.ASID
- tlb_write  in  1  tlbwi|tlbwr issued this cycle
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_vaddr  in  32  virtual address
- req_is_store  in  1  1 = store, 0 = load/fetch
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_paddr  out  32  physical address (0 when resp_exc)
- resp_uncached  out  1  uncached access
- resp_exc  out  1  TLB exception
- resp_exccode  out  5  1=Mod, 2=TLBL, 3=TLBS (0 when !resp_exc)
- resp_refill  out  1  exception is TLB miss (refill vector)
- resp_badvaddr  out  32  faulting vaddr
- tlb_vaddr  out  32  address driven to TLB
- tlb_paddr  in  32  TLB paddr
- tlb_miss, tlb_valid, tlb_dirty, tlb_uncached  in  1 each  TLB result

## Operation
- FSM states: IDLE, LOOKUP, RESP. req_ready = (state==IDLE).
- On accept, vaddr/is_store are registered. The segment is taken from vaddr[31:29]:
  - 100 (kseg0): paddr = {3'b000, vaddr[28:0]}, cached, goto RESP.
  - 101 (kseg1): same paddr, uncached, goto RESP.
  - all others are mapped: goto LOOKUP.
- LOOKUP: tlb_vaddr = registered vaddr. tlb_vaddr holds the registered vaddr in every state; it is 0 after reset.
  - If tlb_write is asserted, stay in LOOKUP and re-sample next cycle, because the array updates on that edge.
  - Otherwise capture the result and goto RESP.
- Classification, first match wins:
  - tlb_miss → exc, refill=1, code TLBL or TLBS by store.
  - !tlb_valid → exc, refill=0, TLBL/TLBS.
  - store && !tlb_dirty → exc, code Mod.
  - else paddr = tlb_paddr, uncached = tlb_uncached.
- The miss check must precede the valid check: the TLB reports valid=1 on miss.
- RESP: outputs held stable until resp_ready; then goto IDLE.
- flush: from any state goto IDLE, response discarded, resp_valid=0 next cycle. flush has priority over accept and over resp_ready.
- rst: every output 0 except req_ready=1; state IDLE; micro-TLB invalid.

## Timing
- Request accepted in cycle N, unmapped or micro-TLB hit: resp_valid in N+1.
- Mapped, micro-TLB miss: resp_valid in N+2, plus 1 for each cycle of tlb_write during LOOKUP.
- No accept while in RESP; back-to-back throughput is one request per 2 cycles (unmapped, resp_ready held high).
- All response outputs are registered; tlb_vaddr is registered.

## Configuration
- MMU_UTLB_EN defined: adds a one-entry micro-TLB holding vpn (vaddr[31:12]), asid, pfn[19:0], uncached and dirty.
  - Filled on every exception-free mapped LOOKUP.
  - A mapped accept whose vpn and asid match a valid entry goes directly to RESP with the cached translation. A store hitting an entry with dirty=0 is treated as a miss.
  - Invalidated on rst, tlb_write, or curr_asid change; an invalidate wins over a same-cycle fill.
- Undefined: every mapped request goes through LOOKUP; no micro-TLB storage.

## Structure
- Shared package mmu_pkg holds:
  - state enum mmu_state_t {IDLE, LOOKUP, RESP};
  - exccode constants EXC_MOD=5'd1, EXC_TLBL=5'd2, EXC_TLBS=5'd3;
  - segment decode function is_mapped(vaddr).
- Natural sub-module: mmu_utlb (micro-TLB entry, compare, fill, invalidate), instantiated only under MMU_UTLB_EN.

## Test plan
- Load 0x8000_1234 → resp N+1, paddr 0x0000_1234, uncached=0, exc=0. Then 0xA000_0010 → paddr 0x0000_0010, uncached=1.
- Load 0x0040_0000, TLB returns miss=1 → N+2: exc=1, code=2, refill=1, badvaddr 0x0040_0000. As a store → code=3.
- Store 0x0040_1000, TLB hit with valid=1, dirty=0 → code=1, refill=0. With dirty=1 and tlb_paddr 0x1FC0_1000 → paddr 0x1FC0_1000, exc=0.
- tlb_write held 2 cycles during LOOKUP → resp_valid at N+4, carrying the post-write TLB result.
- resp_ready held low 5 cycles → outputs stable and req_ready=0 throughout. Assert flush in LOOKUP → resp_valid never rises and req_ready=1 next cycle.
- With MMU_UTLB_EN, repeat the same mapped load → second response at N+1 with an identical paddr. After a curr_asid change or tlb_write, the response is back to N+2.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and helpers for the translation sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: FSM state enum, TLB exception codes, response bundle, segment decode.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } mmu_state_t;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  // Everything the response channel carries besides the valid bit.
  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        exc;
    logic [4:0]  exccode;
    logic        refill;
    logic [31:0] badvaddr;
  } mmu_resp_t;

  // kseg0 (100) and kseg1 (101) bypass the TLB; every other segment is mapped.
  function automatic logic is_mapped(input logic [31:0] vaddr);
    logic [2:0] seg;
    seg = 3'(vaddr >> 29);
    return !((seg == 3'b100) || (seg == 3'b101));
  endfunction

endpackage

// File: rtl/mmu_translate_if.sv
// mmu_translate_if: request/response/TLB signal bundle for mmu_translate.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
// Ports: master = pipeline + TLB array side, slave = mmu_translate.
interface mmu_translate_if;
  logic        flush;
  logic [7:0]  curr_asid;
  logic        tlb_write;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_is_store;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_uncached;
  logic        resp_exc;
  logic [4:0]  resp_exccode;
  logic        resp_refill;
  logic [31:0] resp_badvaddr;
  logic [31:0] tlb_vaddr;
  logic [31:0] tlb_paddr;
  logic        tlb_miss;
  logic        tlb_valid;
  logic        tlb_dirty;
  logic        tlb_uncached;

  modport slave (
    input  flush, curr_asid, tlb_write, req_valid, req_vaddr, req_is_store, resp_ready,
    input  tlb_paddr, tlb_miss, tlb_valid, tlb_dirty, tlb_uncached,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc, resp_exccode,
    output resp_refill, resp_badvaddr, tlb_vaddr
  );

  modport master (
    output flush, curr_asid, tlb_write, req_valid, req_vaddr, req_is_store, resp_ready,
    output tlb_paddr, tlb_miss, tlb_valid, tlb_dirty, tlb_uncached,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc, resp_exccode,
    input  resp_refill, resp_badvaddr, tlb_vaddr
  );
endinterface

// File: rtl/mmu_utlb.sv
// mmu_utlb: one-entry micro-TLB caching the last fault-free mapped translation.
// Latency: combinational hit/data out; fill and invalidate take effect next cycle.
// Backpressure: none; a store to a clean page reports a miss so it takes the full TLB path.
// Ports: clk, rst; i_asid/i_tlb_write (invalidate sources); i_lkp_* -> o_hit/o_pfn/o_uncached; i_fill_*.
module mmu_utlb (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_asid,
  input  logic        i_tlb_write,
  input  logic [19:0] i_lkp_vpn,
  input  logic        i_lkp_store,
  output logic        o_hit,
  output logic [19:0] o_pfn,
  output logic        o_uncached,
  input  logic        i_fill,
  input  logic [19:0] i_fill_vpn,
  input  logic [19:0] i_fill_pfn,
  input  logic        i_fill_uncached,
  input  logic        i_fill_dirty
);
  logic        r_vld;
  logic [19:0] r_vpn;
  logic [19:0] r_pfn;
  logic [7:0]  r_asid;
  logic [7:0]  r_prev_asid;
  logic        r_unc;
  logic        r_dirty;
  logic        w_inval;

  // An ASID change is detected against last cycle's value.
  assign w_inval = i_tlb_write || (i_asid != r_prev_asid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= 1'b0;
      r_vpn       <= '0;
      r_pfn       <= '0;
      r_asid      <= '0;
      r_prev_asid <= '0;
      r_unc       <= 1'b0;
      r_dirty     <= 1'b0;
    end else begin
      r_prev_asid <= i_asid;
      if (w_inval) begin
        r_vld <= 1'b0;              // invalidate beats a same-cycle fill
      end else if (i_fill) begin
        r_vld   <= 1'b1;
        r_vpn   <= i_fill_vpn;
        r_pfn   <= i_fill_pfn;
        r_asid  <= i_asid;
        r_unc   <= i_fill_uncached;
        r_dirty <= i_fill_dirty;
      end
    end
  end

  // Suppress hits in an invalidating cycle so a stale entry never answers.
  assign o_hit = r_vld && !w_inval && (r_vpn == i_lkp_vpn) && (r_asid == i_asid) &&
                 !(i_lkp_store && !r_dirty);
  assign o_pfn      = r_pfn;
  assign o_uncached = r_unc;

endmodule

// File: rtl/mmu_translate.sv
// mmu_translate: one-at-a-time virtual-to-physical translation in front of the TLB array.
// Latency: unmapped or micro-TLB hit -> response next cycle; TLB path 2 cycles, +1 per tlb_write cycle.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready; flush aborts.
// Ports: clk, rst (sync, active-high), bus (mmu_translate_if.slave).
// Build option: define MMU_UTLB_EN to add the one-entry micro-TLB (mmu_utlb).
module mmu_translate
  import mmu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mmu_translate_if.slave bus
);
  mmu_state_t  r_state;
  logic [31:0] r_vaddr;
  logic        r_store;
  logic        r_resp_valid;
  mmu_resp_t   r_resp;

  mmu_resp_t   w_tlb_resp;
  mmu_resp_t   w_fast_resp;
  logic        w_fast;
  logic        w_utlb_hit;
  logic [19:0] w_utlb_pfn;
  logic        w_utlb_unc;

`ifdef MMU_UTLB_EN
  logic w_fill;

  // Fill only when a lookup completes without a fault.
  assign w_fill = (r_state == LOOKUP) && !bus.flush && !bus.tlb_write && !w_tlb_resp.exc;

  mmu_utlb u_utlb (
    .clk             (clk),
    .rst             (rst),
    .i_asid          (bus.curr_asid),
    .i_tlb_write     (bus.tlb_write),
    .i_lkp_vpn       (bus.req_vaddr[31:12]),
    .i_lkp_store     (bus.req_is_store),
    .o_hit           (w_utlb_hit),
    .o_pfn           (w_utlb_pfn),
    .o_uncached      (w_utlb_unc),
    .i_fill          (w_fill),
    .i_fill_vpn      (r_vaddr[31:12]),
    .i_fill_pfn      (bus.tlb_paddr[31:12]),
    .i_fill_uncached (bus.tlb_uncached),
    .i_fill_dirty    (bus.tlb_dirty)
  );
`else
  assign w_utlb_hit = 1'b0;
  assign w_utlb_pfn = '0;
  assign w_utlb_unc = 1'b0;
`endif

  // Requests that can be answered straight from the accept cycle.
  assign w_fast = !is_mapped(bus.req_vaddr) || w_utlb_hit;

  always_comb begin
    w_fast_resp = '0;
    if (!is_mapped(bus.req_vaddr)) begin
      w_fast_resp.paddr    = {3'b000, bus.req_vaddr[28:0]};
      w_fast_resp.uncached = bus.req_vaddr[29];   // kseg1
    end else begin
      w_fast_resp.paddr    = {w_utlb_pfn, bus.req_vaddr[11:0]};
      w_fast_resp.uncached = w_utlb_unc;
    end
  end

  // Miss must be tested before valid: the array reports valid=1 on a miss.
  always_comb begin
    w_tlb_resp = '0;
    if (bus.tlb_miss) begin
      w_tlb_resp.exc      = 1'b1;
      w_tlb_resp.refill   = 1'b1;
      w_tlb_resp.exccode  = r_store ? EXC_TLBS : EXC_TLBL;
      w_tlb_resp.badvaddr = r_vaddr;
    end else if (!bus.tlb_valid) begin
      w_tlb_resp.exc      = 1'b1;
      w_tlb_resp.exccode  = r_store ? EXC_TLBS : EXC_TLBL;
      w_tlb_resp.badvaddr = r_vaddr;
    end else if (r_store && !bus.tlb_dirty) begin
      w_tlb_resp.exc      = 1'b1;
      w_tlb_resp.exccode  = EXC_MOD;
      w_tlb_resp.badvaddr = r_vaddr;
    end else begin
      w_tlb_resp.paddr    = bus.tlb_paddr;
      w_tlb_resp.uncached = bus.tlb_uncached;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vaddr      <= '0;
      r_store      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else if (bus.flush) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_vaddr <= bus.req_vaddr;
            r_store <= bus.req_is_store;
            if (w_fast) begin
              r_resp       <= w_fast_resp;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          // The array is rewritten on a tlb_write edge; sample once it has settled.
          if (!bus.tlb_write) begin
            r_resp       <= w_tlb_resp;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_paddr    = r_resp.paddr;
  assign bus.resp_uncached = r_resp.uncached;
  assign bus.resp_exc      = r_resp.exc;
  assign bus.resp_exccode  = r_resp.exccode;
  assign bus.resp_refill   = r_resp.refill;
  assign bus.resp_badvaddr = r_resp.badvaddr;
  assign bus.tlb_vaddr     = r_vaddr;

endmodule

// File: tb/tb_mmu_translate.sv
// tb_mmu_translate: directed + randomized checks of mmu_translate against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: exercises resp_ready stalls, flush in LOOKUP/RESP and tlb_write stalls.
module tb_mmu_translate;
`ifdef MMU_UTLB_EN
  localparam bit UTLB = 1'b1;
`else
  localparam bit UTLB = 1'b0;
`endif

  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        v;
    logic        d;
    logic        u;
  } tlb_ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_translate_if bus ();
  mmu_translate dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in TLB array: first (lowest index) vpn match wins; a miss reports valid=1.
  tlb_ent_t tlb_e [8];
  always_comb begin
    bus.tlb_miss     = 1'b1;
    bus.tlb_valid    = 1'b1;
    bus.tlb_dirty    = 1'b1;
    bus.tlb_uncached = 1'b0;
    bus.tlb_paddr    = {20'hDEADB, bus.tlb_vaddr[11:0]};
    for (int i = 7; i >= 0; i--) begin
      if (tlb_e[i].vpn == bus.tlb_vaddr[31:12]) begin
        bus.tlb_miss     = 1'b0;
        bus.tlb_valid    = tlb_e[i].v;
        bus.tlb_dirty    = tlb_e[i].d;
        bus.tlb_uncached = tlb_e[i].u;
        bus.tlb_paddr    = {tlb_e[i].pfn, bus.tlb_vaddr[11:0]};
      end
    end
  end

  logic [71:0] w_obs;
  assign w_obs = {bus.resp_paddr, bus.resp_uncached, bus.resp_exc, bus.resp_exccode,
                  bus.resp_refill, bus.resp_badvaddr};

  // Micro-TLB model: the last fault-free translation that went through the TLB.
  bit          m_uv;
  logic [19:0] m_vpn, m_pfn;
  logic [7:0]  m_asid;
  logic        m_u, m_d;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int find(input logic [19:0] vpn);
    for (int i = 0; i < 8; i++) if (tlb_e[i].vpn == vpn) return i;
    return -1;
  endfunction

  // Expected {paddr, uncached, exc, exccode, refill, badvaddr}; exc lands at bit 38.
  function automatic logic [71:0] model(input logic [31:0] va, input logic st, input logic hit);
    logic [31:0] pa;
    logic u, e, rf;
    logic [4:0] c;
    int i;
    pa = 32'h0; u = 1'b0; e = 1'b0; rf = 1'b0; c = 5'd0;
    if (va[31:29] == 3'b100) begin
      pa = va & 32'h1FFF_FFFF;
    end else if (va[31:29] == 3'b101) begin
      pa = va & 32'h1FFF_FFFF;
      u  = 1'b1;
    end else if (hit) begin
      pa = {m_pfn, va[11:0]};
      u  = m_u;
    end else begin
      i = find(va[31:12]);
      if (i < 0) begin
        e = 1'b1; rf = 1'b1; c = st ? 5'd3 : 5'd2;
      end else if (!tlb_e[i].v) begin
        e = 1'b1; c = st ? 5'd3 : 5'd2;
      end else if (st && !tlb_e[i].d) begin
        e = 1'b1; c = 5'd1;
      end else begin
        pa = {tlb_e[i].pfn, va[11:0]};
        u  = tlb_e[i].u;
      end
    end
    return {pa, u, e, c, rf, (e ? va : 32'h0)};
  endfunction

  task automatic set_asid(input logic [7:0] a);
    if (a != bus.curr_asid) m_uv = 1'b0;
    bus.curr_asid = a;
  endtask

  task automatic pulse_write;
    bus.tlb_write = 1'b1;
    m_uv = 1'b0;
    tick;
    bus.tlb_write = 1'b0;
  endtask

  // One full transaction: accept, wait (bounded) for the response, check, stall, release.
  task automatic do_req(input logic [31:0] va, input logic st, input int nwr, input int hold,
                        input int upd_idx, input tlb_ent_t upd_e);
    logic mapped, hit, got;
    int lat, wc, exp_lat, idx;
    logic [71:0] exp;
    mapped  = !((va[31:29] == 3'b100) || (va[31:29] == 3'b101));
    hit     = UTLB && mapped && m_uv && (m_vpn == va[31:12]) && (m_asid == bus.curr_asid) &&
              !(st && !m_d);
    exp_lat = (!mapped || hit) ? 1 : 2 + nwr;
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_vaddr    = va;
    bus.req_is_store = st;
    tick;
    bus.req_valid    = 1'b0;
    bus.req_vaddr    = $urandom;
    bus.req_is_store = 1'($urandom_range(0, 1));
    lat = 1; wc = 0; got = 1'b0;
    while (!got && lat <= 20) begin
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        if (wc < nwr) begin
          bus.tlb_write = 1'b1;
          wc++;
          m_uv = 1'b0;
        end else begin
          bus.tlb_write = 1'b0;
          if (nwr > 0 && upd_idx >= 0) tlb_e[upd_idx] = upd_e;
        end
        tick;
        lat++;
      end
    end
    bus.tlb_write = 1'b0;
    chk("latency", got ? lat : 0, exp_lat);
    exp = model(va, st, hit);
    chk("resp", {bus.resp_valid, w_obs}, {1'b1, exp});
    chk("tlb_vaddr", bus.tlb_vaddr, va);
    chk("req_ready_busy", bus.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold", {bus.resp_valid, bus.req_ready, w_obs}, {1'b1, 1'b0, exp});
    end
    bus.resp_ready = 1'b1;
    tick;
    bus.resp_ready = 1'b0;
    chk("released", {bus.resp_valid, bus.req_ready}, 2'b01);
    if (UTLB && mapped && !hit && !exp[38]) begin
      idx    = find(va[31:12]);
      m_uv   = 1'b1;
      m_vpn  = va[31:12];
      m_asid = bus.curr_asid;
      m_pfn  = tlb_e[idx].pfn;
      m_u    = tlb_e[idx].u;
      m_d    = tlb_e[idx].d;
    end
  endtask

  initial begin
    tlb_ent_t e1;
    logic [31:0] va;
    int sel;
    rst = 1'b1;
    bus.flush = 1'b0; bus.curr_asid = 8'h00; bus.tlb_write = 1'b0;
    bus.req_valid = 1'b0; bus.req_vaddr = 32'h0; bus.req_is_store = 1'b0; bus.resp_ready = 1'b0;
    m_uv = 1'b0; m_vpn = '0; m_pfn = '0; m_asid = '0; m_u = 1'b0; m_d = 1'b0;
    for (int i = 0; i < 8; i++) tlb_e[i] = {20'hFFFFF, 20'h0, 1'b0, 1'b0, 1'b0};
    tlb_e[0] = {20'h00401, 20'h1FC01, 1'b1, 1'b0, 1'b0};
    tlb_e[2] = {20'h00403, 20'h00777, 1'b0, 1'b1, 1'b0};

    repeat (3) tick;
    rst = 1'b0;
    chk("reset_ctl", {bus.req_ready, bus.resp_valid}, 2'b10);
    chk("reset_resp", w_obs, 72'h0);
    chk("reset_tlb_vaddr", bus.tlb_vaddr, 32'h0);

    // Unmapped segments.
    do_req(32'h8000_1234, 1'b0, 0, 0, -1, '0);
    do_req(32'hA000_0010, 1'b0, 0, 0, -1, '0);
    // TLB miss as load and store.
    do_req(32'h0040_0000, 1'b0, 0, 0, -1, '0);
    do_req(32'h0040_0000, 1'b1, 0, 0, -1, '0);
    // Store to a clean page, then to the same page made dirty.
    do_req(32'h0040_1000, 1'b1, 0, 0, -1, '0);
    tlb_e[0].d = 1'b1;
    pulse_write;
    do_req(32'h0040_1000, 1'b1, 0, 0, -1, '0);
    // Invalid entry.
    do_req(32'h0040_3000, 1'b0, 0, 0, -1, '0);
    // Two tlb_write cycles in LOOKUP: the entry appears only after the writes.
    e1 = {20'h00402, 20'h12345, 1'b1, 1'b1, 1'b1};
    do_req(32'h0040_2ABC, 1'b0, 2, 0, 1, e1);
    // Consumer stall.
    do_req(32'h8000_0040, 1'b0, 0, 5, -1, '0);
    // Repeat mapped loads: micro-TLB hits, then ASID change and tlb_write drop them.
    do_req(32'h0040_2DEF, 1'b0, 0, 0, -1, '0);
    set_asid(8'h05);
    do_req(32'h0040_2DEF, 1'b0, 0, 0, -1, '0);
    do_req(32'h0040_2DEF, 1'b0, 0, 1, -1, '0);
    pulse_write;
    do_req(32'h0040_2DEF, 1'b0, 0, 0, -1, '0);

    // Flush during LOOKUP: no response, idle next cycle.
    bus.req_valid = 1'b1; bus.req_vaddr = 32'h0040_0000; bus.req_is_store = 1'b0;
    tick;
    bus.req_valid = 1'b0;
    chk("lookup_state", {bus.resp_valid, bus.req_ready}, 2'b00);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("flush_lookup", {bus.resp_valid, bus.req_ready}, 2'b01);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("flush_quiet", {bus.resp_valid, bus.req_ready}, 2'b01);
    end
    // Flush in RESP beats resp_ready.
    bus.req_valid = 1'b1; bus.req_vaddr = 32'h8000_0000;
    tick;
    bus.req_valid = 1'b0;
    chk("resp_before_flush", bus.resp_valid, 1);
    bus.flush = 1'b1; bus.resp_ready = 1'b1;
    tick;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    chk("flush_resp", {bus.resp_valid, bus.req_ready}, 2'b01);

    // Randomized phase over a freshly written TLB.
    for (int i = 0; i < 8; i++) begin
      e1.vpn = 20'($urandom);
      if (e1.vpn[19:18] == 2'b10) e1.vpn[18] = 1'b1;
      e1.pfn = 20'($urandom);
      e1.v   = ($urandom_range(0, 3) != 0);
      e1.d   = 1'($urandom_range(0, 1));
      e1.u   = 1'($urandom_range(0, 1));
      tlb_e[i] = e1;
    end
    pulse_write;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) set_asid(8'($urandom_range(0, 3)));
      if ($urandom_range(0, 14) == 0) pulse_write;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        va = {2'b10, 30'($urandom)};
      end else if (sel == 3) begin
        va = $urandom;
        if (va[31:30] == 2'b10) va[30] = 1'b1;
      end else begin
        va = {tlb_e[$urandom_range(0, 7)].vpn, 12'($urandom)};
      end
      do_req(va, 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 2), -1, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
